uart_rx_frame_deserializer: RTL and testbench

//  Parametrised UART RX deserializer. Sits between the RX bit sampler and the
//  RX FSM/synchroniser. Counts data and optional parity bits internally and

---
 rtl/uart_rx_frame_deserializer.sv | 98 +++++++++
 tb/tb_uart_rx_frame_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_deserializer.sv
// UART RX frame deserializer: collects payload bits, checks the optional parity bit,
// and hands each completed frame out through a held valid/ready register with overrun detection.
module uart_rx_frame_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_in,
    input  logic                  shift_en_in,
    input  logic                  sampled_bit_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  parity_err_out,
    output logic                  overrun_out,
    output logic                  busy_out
);

    localparam int unsigned N     = DATA_WIDTH + PARITY_EN;
    localparam int unsigned CNT_W = $clog2(N);

    logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_shift_c, payload_c, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_c, payload_bit_c, complete_c, accept_c, err_c;
    logic                  valid_d, perr_d, ovr_d;

    // Shifted value and the payload that a completing strobe would deliver
    always_comb begin
        if (MSB_FIRST != 0) begin
            sh_shift_c = {sh_q[DATA_WIDTH-2:0], sampled_bit_in};
        end else begin
            sh_shift_c = {sampled_bit_in, sh_q[DATA_WIDTH-1:1]};
        end
        // Without parity the final strobe is itself a payload bit
        payload_c     = (PARITY_EN != 0) ? sh_q : sh_shift_c;
        err_c         = (PARITY_EN != 0) && ((^sh_q ^ sampled_bit_in) != 1'(PARITY_ODD));
        last_c        = (32'(cnt_q) == (N - 1));
        payload_bit_c = (32'(cnt_q) < DATA_WIDTH);
        complete_c    = shift_en_in && !clear_in && last_c;
        accept_c      = data_valid_out && data_ready_in;
    end

    // Next-state for the bit counter, shift register and output register
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_out;
        valid_d = data_valid_out;
        perr_d  = parity_err_out;
        ovr_d   = 1'b0;

        if (clear_in) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (shift_en_in) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
            if (payload_bit_c) begin
                sh_d = sh_shift_c;
            end
        end

        if (complete_c) begin
            if (!data_valid_out || data_ready_in) begin
                data_d  = payload_c;
                perr_d  = err_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            sh_q           <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            parity_err_out <= 1'b0;
            overrun_out    <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            sh_q           <= sh_d;
            data_out       <= data_d;
            data_valid_out <= valid_d;
            parity_err_out <= perr_d;
            overrun_out    <= ovr_d;
            busy_out       <= (cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Scoreboard bench: stimulus pushes expected frames, monitors pop them on each accepted handshake.
module tb_uart_rx_frame_deserializer;

    logic clk = 1'b0;
    logic reset_n;

    logic       clear1, shift1, bit1, ready1;
    logic [7:0] data1;
    logic       valid1, perr1, ovr1, busy1;

    logic       clear2, shift2, bit2, ready2;
    logic [4:0] data2;
    logic       valid2, perr2, ovr2, busy2;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;

    logic [8:0] q1[$];
    logic [4:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_frame_deserializer dut1 (
        .clk(clk), .reset_n(reset_n), .clear_in(clear1), .shift_en_in(shift1),
        .sampled_bit_in(bit1), .data_out(data1), .data_valid_out(valid1),
        .data_ready_in(ready1), .parity_err_out(perr1), .overrun_out(ovr1),
        .busy_out(busy1)
    );

    uart_rx_frame_deserializer #(
        .DATA_WIDTH(5), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .clear_in(clear2), .shift_en_in(shift2),
        .sampled_bit_in(bit2), .data_out(data2), .data_valid_out(valid2),
        .data_ready_in(ready2), .parity_err_out(perr2), .overrun_out(ovr2),
        .busy_out(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every accepted handshake must match the oldest expected frame
    always @(negedge clk) begin
        if (reset_n) begin
            if (ovr1) ovr_cnt++;
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_frame", {23'd0, perr1, data1}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = q1.pop_front();
                    chk("dut1_data", 32'(data1), 32'(e[7:0]));
                    chk("dut1_parity_err", 32'(perr1), 32'(e[8]));
                end
            end
            if (valid2 && ready2) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_frame", 32'(data2), 32'h1f);
                end else begin
                    logic [4:0] e2;
                    e2 = q2.pop_front();
                    chk("dut2_data", 32'(data2), 32'(e2));
                    chk("dut2_parity_err", 32'(perr2), 32'd0);
                end
            end
        end
    end

    task automatic strobe1(input logic b);
        shift1 = 1'b1;
        bit1   = b;
        @(posedge clk); #1;
        shift1 = 1'b0;
    endtask

    task automatic payload1(input logic [7:0] d);
        for (int i = 0; i < 8; i++) strobe1(d[i]);
    endtask

    task automatic strobe2(input logic b);
        shift2 = 1'b1;
        bit2   = b;
        @(posedge clk); #1;
        shift2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {clear1, shift1, bit1, ready1} = '0;
        {clear2, shift2, bit2, ready2} = '0;
        idle(2);
        chk("rst_data", 32'(data1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_perr", 32'(perr1), 32'd0);
        chk("rst_ovr", 32'(ovr1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        reset_n = 1'b1;
        idle(1);

        // 1: 0xA5, even parity bit 0
        ready1 = 1'b1;
        q1.push_back({1'b0, 8'hA5});
        payload1(8'hA5);
        chk("t1_valid_before_last", 32'(valid1), 32'd0);
        strobe1(1'b0);
        chk("t1_valid_latency", 32'(valid1), 32'd1);
        chk("t1_data", 32'(data1), 32'hA5);
        idle(1);
        chk("t1_valid_after_accept", 32'(valid1), 32'd0);
        chk("t1_data_held", 32'(data1), 32'hA5);

        // 2: 0xA5 with wrong parity bit
        q1.push_back({1'b1, 8'hA5});
        payload1(8'hA5);
        strobe1(1'b1);
        chk("t2_perr", 32'(perr1), 32'd1);
        idle(1);

        // 3: backpressure, second frame overruns
        ready1 = 1'b0;
        q1.push_back({1'b0, 8'h11});
        payload1(8'h11);
        strobe1(1'b0);
        payload1(8'h22);
        strobe1(1'b0);
        chk("t3_ovr_pulse", 32'(ovr1), 32'd1);
        chk("t3_data_kept", 32'(data1), 32'h11);
        chk("t3_valid_kept", 32'(valid1), 32'd1);
        idle(1);
        chk("t3_ovr_one_cycle", 32'(ovr1), 32'd0);
        ready1 = 1'b1;
        idle(1);
        chk("t3_valid_after_accept", 32'(valid1), 32'd0);

        // 4: accept and completion in the same cycle
        ready1 = 1'b0;
        q1.push_back({1'b0, 8'h11});
        payload1(8'h11);
        strobe1(1'b0);
        q1.push_back({1'b0, 8'h22});
        payload1(8'h22);
        ready1 = 1'b1;
        strobe1(1'b0);
        chk("t4_valid_stays", 32'(valid1), 32'd1);
        chk("t4_data_new", 32'(data1), 32'h22);
        chk("t4_no_ovr", 32'(ovr1), 32'd0);
        idle(1);
        chk("t4_valid_drained", 32'(valid1), 32'd0);

        // 5: partial frame aborted by clear, then a clean frame
        strobe1(1'b1);
        chk("t5_busy_after_first", 32'(busy1), 32'd1);
        strobe1(1'b0);
        strobe1(1'b1);
        strobe1(1'b1);
        clear1 = 1'b1;
        idle(1);
        clear1 = 1'b0;
        chk("t5_busy_after_clear", 32'(busy1), 32'd0);
        q1.push_back({1'b0, 8'h3C});
        payload1(8'h3C);
        strobe1(1'b0);
        chk("t5_data", 32'(data1), 32'h3C);
        chk("t5_perr", 32'(perr1), 32'd0);
        idle(1);

        // 6: MSB-first, 5 bits, no parity; bits 1,0,1,1,0
        ready2 = 1'b1;
        q2.push_back(5'b10110);
        strobe2(1'b1); strobe2(1'b0); strobe2(1'b1); strobe2(1'b1);
        chk("t6_valid_before_last", 32'(valid2), 32'd0);
        strobe2(1'b0);
        chk("t6_valid", 32'(valid2), 32'd1);
        chk("t6_data", 32'(data2), 32'h16);
        idle(1);
        strobe2(1'b1); strobe2(1'b1); strobe2(1'b1);
        chk("t6_busy_mid", 32'(busy2), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy2), 32'd0);
        chk("t6_rst_data2", 32'(data2), 32'd0);
        chk("t6_rst_valid2", 32'(valid2), 32'd0);
        chk("t6_rst_data1", 32'(data1), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        // bits 0,1,0,0,1 -> 5'b01001
        q2.push_back(5'b01001);
        strobe2(1'b0); strobe2(1'b1); strobe2(1'b0); strobe2(1'b0); strobe2(1'b1);
        chk("t6_post_rst_data", 32'(data2), 32'h09);
        chk("t6_post_rst_valid", 32'(valid2), 32'd1);
        idle(3);

        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
        chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
        chk("overrun_pulse_count", 32'(ovr_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
